// File: rtl/pipelined_adder_pkg.sv
// Shared constants and configuration helpers for the pipelined wide adder.
package pipelined_adder_pkg;

  localparam int DEFAULT_WIDTH = 16;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Legal only when the operand splits into whole slices.
  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && ((width % chunk) == 0);
  endfunction

endpackage

// File: rtl/pipelined_adder_chunk_adder.sv
// Combinational W-bit ripple-carry slice used by each pipeline stage.
module chunk_adder #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] s,
  output logic         cout
);

  logic [W:0] w_c;

  always_comb begin
    // NOTE: every output gets a default before the loop so no path leaves one unassigned (no latch).
    s      = '0;
    w_c    = '0;
    w_c[0] = cin;
    for (int i = 0; i < W; i++) begin
      s[i]     = a[i] ^ b[i] ^ w_c[i];
      w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
    end
    cout = w_c[W];
  end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit adder pipelined one CHUNK-bit slice per stage with valid/ready handshake.
// Define PIPELINED_ADDER_OVF_EN to add a registered signed-overflow output.
module pipelined_adder
  import pipelined_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] num_a,
  input  logic [WIDTH-1:0] num_b,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
`ifdef PIPELINED_ADDER_OVF_EN
  ,
  output logic             overflow
`endif
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
    $error("pipelined_adder: WIDTH must be a non-zero multiple of CHUNK");
  end

  logic w_adv;

  // The whole pipe moves as one; a full output register with no taker freezes it.
  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO = k * CHUNK;
    localparam int HI = LO + CHUNK;

    logic             w_v_in;
    logic             w_cin;
    logic             w_cout;
    logic [CHUNK-1:0] w_a_sl;
    logic [CHUNK-1:0] w_b_sl;
    logic [CHUNK-1:0] w_s;
    logic [HI-1:0]    w_sum_d;
    logic             r_valid;
    logic             r_carry;
    logic [HI-1:0]    r_sum;

    if (k == 0) begin : g_first
      assign w_v_in  = in_valid;
      assign w_cin   = carry_in;
      assign w_a_sl  = num_a[CHUNK-1:0];
      assign w_b_sl  = num_b[CHUNK-1:0];
      assign w_sum_d = w_s;
    end else begin : g_next
      assign w_v_in  = g_stage[k-1].r_valid;
      assign w_cin   = g_stage[k-1].r_carry;
      assign w_a_sl  = g_stage[k-1].g_ops.r_a[CHUNK-1:0];
      assign w_b_sl  = g_stage[k-1].g_ops.r_b[CHUNK-1:0];
      assign w_sum_d = {w_s, g_stage[k-1].r_sum};
    end

    chunk_adder #(.W(CHUNK)) u_chunk (
      .a    (w_a_sl),
      .b    (w_b_sl),
      .cin  (w_cin),
      .s    (w_s),
      .cout (w_cout)
    );

    always_ff @(posedge clk) begin
      // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_carry <= 1'b0;
        r_sum   <= '0;
      end else if (w_adv) begin
        r_valid <= w_v_in;
        if (w_v_in) begin
          r_carry <= w_cout;
          r_sum   <= w_sum_d;
        end
      end
    end

    // Operand bits not yet consumed ride along, re-based so the next slice sits at bit 0.
    if (HI < WIDTH) begin : g_ops
      logic [WIDTH-HI-1:0] w_a_up;
      logic [WIDTH-HI-1:0] w_b_up;
      logic [WIDTH-HI-1:0] r_a;
      logic [WIDTH-HI-1:0] r_b;

      if (k == 0) begin : g_src0
        assign w_a_up = num_a[WIDTH-1:HI];
        assign w_b_up = num_b[WIDTH-1:HI];
      end else begin : g_srcn
        assign w_a_up = g_stage[k-1].g_ops.r_a[WIDTH-LO-1:CHUNK];
        assign w_b_up = g_stage[k-1].g_ops.r_b[WIDTH-LO-1:CHUNK];
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv && w_v_in) begin
          r_a <= w_a_up;
          r_b <= w_b_up;
        end
      end
    end

    if (k == STAGES - 1) begin : g_out
      assign out_valid = r_valid;
      assign sum       = r_sum;
      assign carry_out = r_carry;

`ifdef PIPELINED_ADDER_OVF_EN
      logic w_c_msb;
      logic r_ovf;

      // Carry into the MSB recovered from the MSB's own sum bit.
      assign w_c_msb = w_a_sl[CHUNK-1] ^ w_b_sl[CHUNK-1] ^ w_s[CHUNK-1];

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_ovf <= 1'b0;
        end else if (w_adv && w_v_in) begin
          r_ovf <= w_c_msb ^ w_cout;
        end
      end

      assign overflow = r_ovf;
`endif
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Self-checking bench for pipelined_adder (WIDTH=16, CHUNK=4) against an arithmetic reference model.
module tb_pipelined_adder;

  localparam int W   = 16;
  localparam int STG = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] num_a;
  logic [W-1:0] num_b;
  logic         carry_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         carry_out;
`ifdef PIPELINED_ADDER_OVF_EN
  logic         overflow;
`endif

  pipelined_adder #(.WIDTH(W), .CHUNK(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .num_a     (num_a),
    .num_b     (num_b),
    .carry_in  (carry_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
`ifdef PIPELINED_ADDER_OVF_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
  } res_t;

  res_t exp_q[$];
  int   acc_cyc_q[$];
  int   out_cyc_q[$];
  int   out_lat_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc      = 0;
  int   n_acc    = 0;
  int   n_out    = 0;
  int   n_stall  = 0;

  function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
    res_t        r;
    int unsigned full;
    int          s;
    full   = 32'(a) + 32'(b) + 32'(c);
    r.sum  = full[W-1:0];
    r.cout = full[W];
    s      = int'($signed(a)) + int'($signed(b)) + int'(c);
    r.ovf  = (s > 32767) || (s < -32768);
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: apply inputs, settle, score the handshake, then advance past the edge.
  task automatic drive_cycle(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic c, input logic ordy);
    res_t e;
    in_valid  = v;
    num_a     = a;
    num_b     = b;
    carry_in  = c;
    out_ready = ordy;
    #1;
    if (out_valid === 1'b1 && !ordy) begin
      n_stall++;
      check("in_ready_stall", 32'(in_ready), 32'd0);
      if (exp_q.size() > 0) check("sum_hold", 32'(sum), 32'(exp_q[0].sum));
    end
    if (out_valid === 1'b1 && ordy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", 32'(out_valid), 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e.sum));
        check("carry_out", 32'(carry_out), 32'(e.cout));
`ifdef PIPELINED_ADDER_OVF_EN
        check("overflow", 32'(overflow), 32'(e.ovf));
`endif
        out_lat_q.push_back(cyc - acc_cyc_q.pop_front());
        out_cyc_q.push_back(cyc);
        n_out++;
      end
    end
    if (v && in_ready === 1'b1) begin
      exp_q.push_back(model(a, b, c));
      acc_cyc_q.push_back(cyc);
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++) begin
      if (exp_q.size() == 0) break;
      drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    end
    check("drain_pending", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    int acc0;
    int out0;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    num_a     = '0;
    num_b     = '0;
    carry_in  = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_carry_out", 32'(carry_out), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef PIPELINED_ADDER_OVF_EN
    check("rst_overflow", 32'(overflow), 32'd0);
`endif

    // Single add and latency
    out_lat_q.delete();
    drive_cycle(1'b1, 16'h0001, 16'h0002, 1'b0, 1'b1);
    drain();
    check("latency_count", 32'(out_lat_q.size()), 32'd1);
    if (out_lat_q.size() > 0) check("latency", 32'(out_lat_q[0]), 32'(STG));

    // Wrap-around corners
    drive_cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'hFFFF, 16'hFFFF, 1'b1, 1'b1);
    drive_cycle(1'b1, 16'hFFFF, 16'h0000, 1'b1, 1'b1);
    drain();

    // Back-to-back random stream
    out_cyc_q.delete();
    for (int i = 0; i < 8; i++)
      drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    drain();
    check("stream_count", 32'(out_cyc_q.size()), 32'd8);
    if (out_cyc_q.size() == 8) check("stream_span", 32'(out_cyc_q[7] - out_cyc_q[0]), 32'd7);

    // Back-pressure: five stalled cycles mid-stream
    acc0    = n_acc;
    out0    = n_out;
    n_stall = 0;
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    for (int i = 0; i < 5; i++)
      drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    drain();
    check("stall_cycles", 32'(n_stall), 32'd5);
    check("stall_accepts", 32'(n_acc - acc0), 32'd8);
    check("stall_in_out", 32'(n_out - out0), 32'(n_acc - acc0));

    // Reset with three adds in flight
    for (int i = 0; i < 3; i++)
      drive_cycle(1'b1, 16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    acc_cyc_q.delete();
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_sum", 32'(sum), 32'd0);
    check("midrst_carry_out", 32'(carry_out), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) drive_cycle(1'b0, '0, '0, 1'b0, 1'b1);
    check("midrst_quiet", 32'(out_valid), 32'd0);

    // Random valid and back-pressure mix
    acc0 = n_acc;
    out0 = n_out;
    for (int i = 0; i < 60; i++)
      drive_cycle(1'($urandom), 16'($urandom), 16'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) != 0));
    drain();
    check("mix_in_out", 32'(n_out - out0), 32'(n_acc - acc0));

`ifdef PIPELINED_ADDER_OVF_EN
    // Signed overflow corners
    drive_cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'h8000, 16'hFFFF, 1'b0, 1'b1);
    drive_cycle(1'b1, 16'h1234, 16'h4321, 1'b0, 1'b1);
    drain();
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's combinational 4-bit ripple adder: WIDTH-bit add with carry-in, carry chain split into CHUNK-bit slices, one register stage per slice.
- valid/ready handshake on input and output; sustains one add per cycle; global stall under back-pressure.
- Sits in the datapath lab designs as the reusable wide adder feeding accumulators and ALU blocks.

Parameters:
- WIDTH, 16, operand and sum width in bits; must be a multiple of CHUNK.
- CHUNK, 4, bits added per pipeline stage; STAGES = WIDTH/CHUNK (derived, not overridable).

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  synchronous, active-low reset.
- in_valid  in  1  operands present on num_a/num_b/carry_in.
- in_ready  out  1  block accepts operands this cycle.
- num_a  in  WIDTH  operand A, unsigned.
- num_b  in  WIDTH  operand B, unsigned.
- carry_in  in  1  carry into bit 0.
- out_valid  out  1  sum/carry_out hold a result.
- out_ready  in  1  consumer accepts result this cycle.
- sum  out  WIDTH  num_a + num_b + carry_in, modulo 2^WIDTH.
- carry_out  out  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid bits, out_valid, sum, carry_out cleared to 0; in-flight data discarded; in_ready = 1 during the cycle after reset. Reset mid-operation drops every pending result, no partial output.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] of A and B plus the carry registered by stage k-1 (stage 0 uses carry_in). Lower sum slices already computed and upper operand slices still pending travel alongside in stage registers.
- Latency: result for an accept at cycle t appears with out_valid=1 at cycle t+STAGES when not stalled. STAGES=1 (CHUNK=WIDTH) gives 1-cycle latency.
- Advance enable: adv = !out_valid || out_ready. All stages shift together when adv=1; all hold when adv=0.
- in_ready = adv (combinational). Input accepted only on in_valid && in_ready.
- Output transfer on out_valid && out_ready. Simultaneous input accept and output transfer in the same cycle is legal: full throughput, one result per cycle.
- Bubbles are not compressed; a stage with valid=0 still shifts on adv.
- sum/carry_out hold their value while out_valid=1 and out_ready=0 and must not change until transfer.
- Wrap-around: all-ones + 0 + carry_in=1 gives sum=0, carry_out=1; no saturation.
- Stage data registers may skip updating when the incoming valid=0; valid bits always update.

Optional Feature:
- Macro PIPELINED_ADDER_OVF_EN.
- Defined: adds output port overflow (out, 1). It equals signed two's-complement overflow of the add (carry into MSB XOR carry_out). It is registered and aligned with sum, reset to 0, and held under stall like sum.
- Undefined: port and logic absent; all other behaviour unchanged.

Decomposition:
- Package pipelined_adder_pkg: default WIDTH/CHUNK constants, a function computing STAGES, and an elaboration-time check that WIDTH % CHUNK == 0.
- One sub-module chunk_adder: combinational CHUNK-bit ripple adder (a, b, cin -> s, cout), instantiated STAGES times via generate.

Test Plan (WIDTH=16, CHUNK=4, STAGES=4):
- Reset then A=0x0001, B=0x0002, cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; sum=0x0003, carry_out=0.
- A=0xFFFF, B=0x0001, cin=0 -> sum=0x0000, carry_out=1; also A=0xFFFF, B=0xFFFF, cin=1 -> sum=0xFFFF, carry_out=1.
- Back-to-back stream of 8 random operand pairs with out_ready=1 -> 8 consecutive out_valid cycles, results in order, each matching the reference model.
- Stream with out_ready held 0 for 5 cycles mid-stream -> in_ready drops while out_valid=1; sum is stable while stalled; no result is lost or duplicated after release.
- Assert rst_n=0 for 1 cycle with 3 adds in flight -> next cycle out_valid=0 and sum=0; no stale results emerge afterwards.
- With PIPELINED_ADDER_OVF_EN defined: A=0x7FFF, B=0x0001 -> overflow=1, sum=0x8000; A=0x8000, B=0xFFFF -> overflow=1, carry_out=1.
